// File: rtl/alu_mdu_seq.sv
// Handshaked integer execute unit: single-cycle ALU ops plus RV32M-style
// multiply/divide on a shared radix-2 iterative datapath, one op in flight.
module alu_mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SLL  = 5'b00101;
  localparam logic [4:0] OP_SRL  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_SRA  = 5'b01110;
  localparam logic [4:0] OP_SLTU = 5'b01111;
  localparam logic [4:0] OP_LUI  = 5'b10000;
  localparam logic [4:0] OP_SLLI = 5'b10001;
  localparam logic [4:0] OP_SRLI = 5'b10010;
  localparam logic [4:0] OP_SRAI = 5'b10011;

  typedef enum logic [1:0] {
    IDLE,
    MUL_BUSY,
    DIV_BUSY,
    DONE
  } state_t;

  state_t state;

  logic [SHW-1:0]    count;
  logic              last;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic              b_signed_q;
  logic              high_q;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   dvs;
  logic              neg_q;
  logic              neg_r;
  logic              rem_op;

  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   alu_res;
  logic              is_mul;
  logic              is_div;
  logic              mul_a_signed;
  logic              div_signed;
  logic              div_zero;
  logic              div_ovf;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   div_special;

  logic [2*XLEN-1:0] acc_next;
  logic [XLEN:0]     div_trial;
  logic [XLEN:0]     div_diff;
  logic [XLEN-1:0]   quo_next;
  logic [XLEN-1:0]   rem_next;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  assign shamt = src_b[SHW-1:0];
  assign last  = (count == SHW'(XLEN - 1));

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:           alu_res = src_a + src_b;
      OP_SUB:           alu_res = src_a - src_b;
      OP_AND:           alu_res = src_a & src_b;
      OP_OR:            alu_res = src_a | src_b;
      OP_XOR:           alu_res = src_a ^ src_b;
      OP_SLL, OP_SLLI:  alu_res = src_a << shamt;
      OP_SRL, OP_SRLI:  alu_res = src_a >> shamt;
      OP_SRA, OP_SRAI:  alu_res = $signed(src_a) >>> shamt;
      OP_SLT:           alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU:          alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      OP_LUI:           alu_res = src_a << 12;
      default:          alu_res = '0;
    endcase
  end

  // Multiply/divide variants are selected by op[1:0] within their op[4:2] group.
  assign is_mul       = (op[4:2] == 3'b101);
  assign is_div       = (op[4:2] == 3'b110);
  assign mul_a_signed = (op[1:0] != 2'b11);
  assign div_signed   = ~op[0];
  assign div_zero     = (src_b == '0);
  assign div_ovf      = div_signed && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
  assign a_neg        = div_signed & src_a[XLEN-1];
  assign b_neg        = div_signed & src_b[XLEN-1];
  assign a_mag        = a_neg ? -src_a : src_a;
  assign b_mag        = b_neg ? -src_b : src_b;

  always_comb begin
    div_special = '0;
    if (div_zero) begin
      div_special = op[1] ? src_a : '1;
    end else begin
      div_special = op[1] ? '0 : src_a;
    end
  end

  // A signed multiplier's top bit carries weight -2^(XLEN-1), so the last step subtracts.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      if (last && b_signed_q) begin
        acc_next = acc - mcand;
      end else begin
        acc_next = acc + mcand;
      end
    end
  end

  always_comb begin
    div_trial = {rem, quo[XLEN-1]};
    div_diff  = div_trial - {1'b0, dvs};
    if (!div_diff[XLEN]) begin
      rem_next = div_diff[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = div_trial[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
    quo_fix = neg_q ? -quo_next : quo_next;
    rem_fix = neg_r ? -rem_next : rem_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      result     <= '0;
      count      <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      b_signed_q <= 1'b0;
      high_q     <= 1'b0;
      quo        <= '0;
      rem        <= '0;
      dvs        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      rem_op     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            count    <= '0;
            in_ready <= 1'b0;
            if (is_mul) begin
              acc        <= '0;
              mcand      <= {{XLEN{mul_a_signed & src_a[XLEN-1]}}, src_a};
              mplier     <= src_b;
              b_signed_q <= ~op[1];
              high_q     <= (op[1:0] != 2'b00);
              busy       <= 1'b1;
              state      <= MUL_BUSY;
            end else if (is_div && !div_zero && !div_ovf) begin
              quo    <= a_mag;
              rem    <= '0;
              dvs    <= b_mag;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              rem_op <= op[1];
              busy   <= 1'b1;
              state  <= DIV_BUSY;
            end else begin
              result    <= is_div ? div_special : alu_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        MUL_BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + SHW'(1);
          if (last) begin
            result    <= high_q ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DIV_BUSY: begin
          quo   <= quo_next;
          rem   <= rem_next;
          count <= count + SHW'(1);
          if (last) begin
            result    <= rem_op ? rem_fix : quo_fix;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(result)));

  assert property (@(posedge clk) disable iff (!rst_n)
    busy |-> (!in_ready && !out_valid));

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Scoreboard bench for alu_mdu_seq: directed corner cases plus randomized ops
// against an arithmetic reference model, with a decoupled output monitor.
module tb_alu_mdu_seq;

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SRA = 5'd14, SLT = 5'd7, SLTU = 5'd15;
  localparam logic [4:0] LUI = 5'd16, MUL = 5'd20, MULH = 5'd21, MULHSU = 5'd22, MULHU = 5'd23;
  localparam logic [4:0] DIV = 5'd24, DIVU = 5'd25, REM = 5'd26, REMU = 5'd27;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] exp;
    int          lat;
    int          acc;
  } sb_t;

  sb_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          issued = 0;
  int          received = 0;
  int          last_acc = 0;
  bit          pending = 0;
  bit          rand_ready = 0;
  logic [4:0]  r_op;
  logic [31:0] r_a, r_b;

  alu_mdu_seq #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] refModel(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    int          sa, sbv;
    longint      x, y;
    logic [63:0] p;
    logic [4:0]  sh;
    sa  = a;
    sbv = b;
    sh  = b[4:0];
    case (o)
      5'd0:         return a + b;
      5'd1:         return a - b;
      5'd2:         return a & b;
      5'd3:         return a | b;
      5'd4:         return a ^ b;
      5'd5, 5'd17:  return a << sh;
      5'd6, 5'd18:  return a >> sh;
      5'd14, 5'd19: return sa >>> sh;
      5'd7:         return (sa < sbv) ? 32'd1 : 32'd0;
      5'd15:        return (a < b) ? 32'd1 : 32'd0;
      5'd16:        return a << 12;
      5'd20, 5'd21, 5'd22, 5'd23: begin
        x = (o == 5'd23) ? longint'({32'b0, a}) : longint'(sa);
        y = (o == 5'd20 || o == 5'd21) ? longint'(sbv) : longint'({32'b0, b});
        p = x * y;
        return (o == 5'd20) ? p[31:0] : p[63:32];
      end
      5'd24: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sbv;
      end
      5'd25:        return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd26: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sbv;
      end
      5'd27:        return (b == 0) ? a : a % b;
      default:      return 32'd0;
    endcase
  endfunction

  function automatic int refLatency(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o >= 5'd20 && o <= 5'd23) return 33;
    if (o >= 5'd24 && o <= 5'd27) begin
      if (b == 0) return 1;
      if ((o == 5'd24 || o == 5'd26) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    return 1;
  endfunction

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Presents one request aligned to a clock edge and records it when accepted.
  task automatic applyStimulus(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp, input int lat);
    int waited = 0;
    @(posedge clk);
    #1;
    op = o;
    src_a = a;
    src_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    sb.push_back('{o, exp, lat, cyc});
    issued++;
    last_acc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got %h with no request outstanding", result);
      end else begin
        if (!pending) begin
          pending = 1;
          checkOutput($sformatf("latency op%0d", sb[0].op), 32'(cyc - sb[0].acc), 32'(sb[0].lat));
        end
        checkOutput($sformatf("result op%0d", sb[0].op), result, sb[0].exp);
        if (out_ready) begin
          void'(sb.pop_front());
          pending = 0;
          received++;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not end, %0d results outstanding", sb.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] reset in the middle of a MUL");
    applyStimulus(MUL, 32'd1234, 32'd5678, 32'd7006652, 33);
    repeat (4) @(posedge clk);
    #2;
    checkOutput("mul busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort busy", 32'(busy), 32'd0);
    issued -= sb.size();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(ADD, 32'd2, 32'd3, 32'd5, 1);

    $display("[TB] single-cycle op set");
    applyStimulus(ADD,  32'h7FFF_FFFF, 32'h1,        32'h8000_0000, 1);
    applyStimulus(SUB,  32'h0,         32'h1,        32'hFFFF_FFFF, 1);
    applyStimulus(SRA,  32'h8000_0000, 32'h24,       32'hF800_0000, 1);
    applyStimulus(SLT,  32'hFFFF_FFFF, 32'h1,        32'h1,         1);
    applyStimulus(SLTU, 32'hFFFF_FFFF, 32'h1,        32'h0,         1);
    applyStimulus(LUI,  32'h12345,     32'h0,        32'h1234_5000, 1);
    applyStimulus(5'd30, 32'hDEAD_BEEF, 32'h5,       32'h0,         1);

    $display("[TB] multiply");
    applyStimulus(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         33);
    applyStimulus(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    applyStimulus(MUL,    32'h0001_0000, 32'h0001_0000, 32'h0,         33);
    applyStimulus(MULHSU, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 33);

    $display("[TB] divide");
    applyStimulus(DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    applyStimulus(REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    applyStimulus(DIVU, 32'd100,       32'd7,         32'd14,        33);
    applyStimulus(DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    applyStimulus(REMU, 32'd5,         32'd0,         32'd5,         1);
    applyStimulus(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    applyStimulus(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);

    $display("[TB] output backpressure");
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(ADD, 32'd10, 32'd20, 32'd30, 1);
    fork
      applyStimulus(SUB, 32'd50, 32'd8, 32'd42, 1);
      begin
        int w = 0;
        int hs;
        while (!out_valid && w < 100) begin
          @(negedge clk);
          w++;
        end
        checkOutput("bp out_valid seen", 32'(out_valid), 32'd1);
        repeat (10) begin
          @(negedge clk);
          checkOutput("bp out_valid held", 32'(out_valid), 32'd1);
          checkOutput("bp in_ready low", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        hs = cyc;
        wait (last_acc > hs || cyc > hs + 50);
        checkOutput("bp accept after handshake", 32'(last_acc - hs), 32'd1);
      end
    join

    $display("[TB] randomized ops");
    rand_ready = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      r_op = 5'($urandom_range(0, 31));
      r_a  = randOperand();
      r_b  = randOperand();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      applyStimulus(r_op, r_a, r_b, refModel(r_op, r_a, r_b), refLatency(r_op, r_a, r_b));
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int w = 0; w < 200 && sb.size() != 0; w++) @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput("outstanding results", 32'(sb.size()), 32'd0);
    checkOutput("results received", 32'(received), 32'(issued));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
